qpu_tcm_arb_ctrl: RTL and testbench
===================================

# qpu_tcm_arb_ctrl

Parametrised tightly-coupled-memory controller. It arbitrates NPORT single-transaction ICB requesters, such as the IFU fetch path and the program loader, onto one single-port synchronous SRAM using round-robin. It supports back-to-back pipelined access and a response-stall holding register, and it exports a RAM clock-enable with a cgstop override. It sits between the QPU fetch/load masters and the ITCM macro, and generalises the single-requester ITCM controller.

## Interface
- NPORT, 2, number of ICB requesters (≥1)
- DW, 64, data width in bits
- AW, 16, byte-address width
- AW_LSB, 3, log2(DW/8); address bits dropped before the RAM
- MW, DW/8, write-mask width
- RAM_AW, AW-AW_LSB, RAM word-address width

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- tcm_cgstop  in  1  forces ram_clk_en high (debug)
- i_cmd_valid  in  NPORT  per-port command valid
- i_cmd_ready  out  NPORT  per-port command ready
- i_cmd_read  in  NPORT  1=read, 0=write
- i_cmd_addr  in  NPORT*AW  packed byte addresses, port k at [k*AW +: AW]
- i_cmd_wdata  in  NPORT*DW  packed write data
- i_cmd_wmask  in  NPORT*MW  packed byte-enables
- i_rsp_valid  out  NPORT  one-hot response valid
- i_rsp_ready  in  NPORT  per-port response ready
- i_rsp_rdata  out  DW  shared response data
- ram_cs, ram_we  out  1 each  RAM select and write enable
- ram_addr  out  RAM_AW  = granted addr[AW-1:AW_LSB]
- ram_wem  out  MW  write byte mask, 0 on reads
- ram_din  out  DW  write data
- ram_dout  in  DW  RAM read data, valid the cycle after ram_cs
- ram_clk_en  out  1  = ram_cs | tcm_cgstop
- tcm_active  out  1  = |i_cmd_valid | outstanding

## Operation
- One outstanding transaction total. The state is {outstanding, owner[log2 NPORT], was_read, held}.
- Accept condition: `can_issue = !outstanding | (rsp handshake of the owner this cycle)`.
- Arbiter:
  - Round-robin pointer `ptr` marks the highest-priority port.
  - Grant goes to the first valid port at or above `ptr`, modulo NPORT.
  - `i_cmd_ready[k] = grant[k] & can_issue`; all other ports see ready 0.
- On accept, in the same cycle:
  - `ram_cs=1`; `ram_we=!read`; `ram_wem = read ? 0 : wmask`.
  - `ptr <= (granted+1) mod NPORT`, wrapping from NPORT-1 to 0.
  - `owner <= granted`; `outstanding <= 1`; `held <= 0`.
- Response:
  - `i_rsp_valid[owner]` is 1 while outstanding.
  - `i_rsp_rdata = was_read ? (held ? hold_reg : ram_dout) : 0`.
- Stall: in the first response cycle with rsp_ready low, capture ram_dout into hold_reg and set `held`. Data stays stable until the handshake. The RAM is not re-accessed.
- Handshake without a new accept clears `outstanding`.
- Writes complete with a response carrying rdata=0.
- Reset: `outstanding=0`, `ptr=0`, `held=0`, `hold_reg=0`. Any in-flight response is dropped silently.
- Reset values of outputs: i_cmd_ready=0 (while rst is asserted), i_rsp_valid=0, i_rsp_rdata=0, ram_cs=0, ram_we=0, ram_wem=0, ram_clk_en=tcm_cgstop.

## Timing
- Read latency: accept in cycle N, rsp_valid and rdata in N+1.
- Throughput: one transaction per cycle when rsp_ready is held high. An accept in N+1 overlaps the response of N.
- Allowed combinational paths: i_cmd_valid→i_cmd_ready, i_rsp_ready→i_cmd_ready, i_cmd_*→ram_*.
- i_rsp_valid and owner are registered. rdata is combinational from ram_dout only in the first response cycle.
- Same-cycle events:
  - A new request while the owner stalls gets no grant and ptr does not move.
  - If rst is high together with a valid command, the command is not accepted.
- NPORT=1: the arbiter degenerates to a pass-through and ptr stays 0.

## Structure
- Shared package `qpu_tcm_pkg`:
  - clog2-based index-width constant
  - the default DW/AW/AW_LSB values
  - the response-source encoding (RAM, HOLD, ZERO)
- Sub-module `qpu_rr_arb` (parameter NPORT):
  - inputs: req vector, ptr, advance
  - outputs: one-hot grant, encoded index, registered ptr
- Everything else is inline in `qpu_tcm_arb_ctrl`.

## Test plan
- Single read, port 0, addr 0x0010, ram_dout=0xDEAD_BEEF_0000_0001 → ram_addr=0x002, rsp_valid[0] at N+1 with that data.
- Both ports request continuously with reads, rsp_ready=1 → grants alternate 0,1,0,1, one response per cycle, ptr wraps 1→0.
- Read, then rsp_ready=0 for 3 cycles while ram_dout changes to garbage → rdata stays the originally captured value, no ram_cs, port 1 is not granted until the handshake.
- Write, port 1, addr 0x0008, wmask=0x0F, wdata=0x1122334455667788 → ram_we=1, ram_wem=0x0F, ram_addr=0x001, response rdata=0. A following read of 0x0008 returns the RAM contents.
- Assert rst while a response is pending → next cycle rsp_valid=0, ptr=0. First request after rst deasserts gets latency 1.
- tcm_cgstop=1 while idle → ram_clk_en=1, ram_cs=0. With tcm_cgstop=0, ram_clk_en follows ram_cs exactly.

Source files
------------

// File: rtl/qpu_tcm_pkg.sv
// rtl/qpu_tcm_pkg.sv - shared constants and types for the QPU TCM arbiter/controller
package qpu_tcm_pkg;

  localparam int DEF_DW     = 64;
  localparam int DEF_AW     = 16;
  localparam int DEF_AW_LSB = 3;

  // Where the shared response data comes from in a given cycle
  typedef enum logic [1:0] {
    RSP_RAM  = 2'd0,
    RSP_HOLD = 2'd1,
    RSP_ZERO = 2'd2
  } rsp_src_e;

  // Port-index width; a single requester still needs a 1-bit index
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qpu_rr_arb.sv
// rtl/qpu_rr_arb.sv - round-robin arbiter, priority pointer advances past each accepted grant
module qpu_rr_arb
  import qpu_tcm_pkg::*;
#(
  parameter int NPORT = 2,
  localparam int IW = idx_w(NPORT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic             advance,
  output logic [NPORT-1:0] grant,
  output logic [IW-1:0]    idx
);

  logic [IW-1:0] ptr;

  always_comb begin : sel
    int   k;
    logic found;
    k     = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < NPORT; i++) begin
      k = int'(ptr) + i;
      if (k >= NPORT) k = k - NPORT;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(idx) == NPORT - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/qpu_tcm_arb_ctrl.sv
// rtl/qpu_tcm_arb_ctrl.sv - NPORT-requester ICB to single-port SRAM controller, one transaction in flight
module qpu_tcm_arb_ctrl
  import qpu_tcm_pkg::*;
#(
  parameter int NPORT  = 2,
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int AW_LSB = DEF_AW_LSB,
  parameter int MW     = DW / 8,
  parameter int RAM_AW = AW - AW_LSB
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tcm_cgstop,
  input  logic [NPORT-1:0]    i_cmd_valid,
  output logic [NPORT-1:0]    i_cmd_ready,
  input  logic [NPORT-1:0]    i_cmd_read,
  input  logic [NPORT*AW-1:0] i_cmd_addr,
  input  logic [NPORT*DW-1:0] i_cmd_wdata,
  input  logic [NPORT*MW-1:0] i_cmd_wmask,
  output logic [NPORT-1:0]    i_rsp_valid,
  input  logic [NPORT-1:0]    i_rsp_ready,
  output logic [DW-1:0]       i_rsp_rdata,
  output logic                ram_cs,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [MW-1:0]       ram_wem,
  output logic [DW-1:0]       ram_din,
  input  logic [DW-1:0]       ram_dout,
  output logic                ram_clk_en,
  output logic                tcm_active
);

  localparam int IW = idx_w(NPORT);

  logic             outstanding;
  logic [IW-1:0]    owner;
  logic             was_read;
  logic             held;
  logic [DW-1:0]    hold_reg;

  logic [NPORT-1:0] grant;
  logic [IW-1:0]    idx;
  logic             rsp_hs;
  logic             can_issue;
  logic             accept;
  logic             sel_read;
  rsp_src_e         rsp_src;

  assign rsp_hs    = outstanding & i_rsp_ready[owner];
  assign can_issue = ~outstanding | rsp_hs;
  assign accept    = (|i_cmd_valid) & can_issue & ~rst;

  qpu_rr_arb #(.NPORT(NPORT)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (i_cmd_valid),
    .advance (accept),
    .grant   (grant),
    .idx     (idx)
  );

  assign i_cmd_ready = grant & {NPORT{can_issue & ~rst}};
  assign sel_read    = i_cmd_read[idx];

  // RAM side is driven straight from the granted port in the accept cycle
  assign ram_cs     = accept;
  assign ram_we     = accept & ~sel_read;
  assign ram_wem    = (accept & ~sel_read) ? i_cmd_wmask[int'(idx)*MW +: MW] : '0;
  assign ram_addr   = accept ? i_cmd_addr[int'(idx)*AW + AW_LSB +: RAM_AW] : '0;
  assign ram_din    = accept ? i_cmd_wdata[int'(idx)*DW +: DW] : '0;
  assign ram_clk_en = ram_cs | tcm_cgstop;
  assign tcm_active = (|i_cmd_valid) | outstanding;

  always_comb begin
    rsp_src = RSP_ZERO;
    if (outstanding && was_read) rsp_src = held ? RSP_HOLD : RSP_RAM;
  end

  always_comb begin
    case (rsp_src)
      RSP_RAM:  i_rsp_rdata = ram_dout;
      RSP_HOLD: i_rsp_rdata = hold_reg;
      default:  i_rsp_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= 1'b0;
      owner       <= '0;
      was_read    <= 1'b0;
      held        <= 1'b0;
      hold_reg    <= '0;
      i_rsp_valid <= '0;
    end else if (accept) begin
      outstanding <= 1'b1;
      owner       <= idx;
      was_read    <= sel_read;
      held        <= 1'b0;
      i_rsp_valid <= grant;
    end else if (rsp_hs) begin
      outstanding <= 1'b0;
      held        <= 1'b0;
      i_rsp_valid <= '0;
    end else if (outstanding && !held) begin
      // RAM output is only guaranteed for one cycle; park it until the owner takes it
      hold_reg <= ram_dout;
      held     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qpu_tcm_arb_ctrl.sv
// tb/tb_qpu_tcm_arb_ctrl.sv - vector table plus randomized run against a transaction-level model
module tb_qpu_tcm_arb_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         tcm_cgstop;
  logic [1:0]   i_cmd_valid, i_cmd_ready, i_cmd_read;
  logic [31:0]  i_cmd_addr;
  logic [127:0] i_cmd_wdata;
  logic [15:0]  i_cmd_wmask;
  logic [1:0]   i_rsp_valid, i_rsp_ready;
  logic [63:0]  i_rsp_rdata;
  logic         ram_cs, ram_we, ram_clk_en, tcm_active;
  logic [12:0]  ram_addr;
  logic [7:0]   ram_wem;
  logic [63:0]  ram_din, ram_dout;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [0:8191];

  qpu_tcm_arb_ctrl dut (
    .clk(clk), .rst(rst), .tcm_cgstop(tcm_cgstop),
    .i_cmd_valid(i_cmd_valid), .i_cmd_ready(i_cmd_ready), .i_cmd_read(i_cmd_read),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wmask(i_cmd_wmask),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_rdata(i_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_clk_en(ram_clk_en), .tcm_active(tcm_active)
  );

  always #5 clk = ~clk;

  // SRAM: data appears the cycle after a read select, otherwise the output is junk
  always @(posedge clk) begin
    if (ram_cs && ram_we) begin
      for (int b = 0; b < 8; b++)
        if (ram_wem[b]) mem[ram_addr][b*8 +: 8] = ram_din[b*8 +: 8];
    end
    if (ram_cs && !ram_we) ram_dout <= mem[ram_addr];
    else                   ram_dout <= {$urandom, $urandom};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rst; logic [1:0] vld, rd; logic [15:0] a0, a1; logic [63:0] wd; logic [7:0] wm;
    logic [1:0] rr; logic cg;
    logic [1:0] crdy, rv; logic [63:0] rdata; logic cs, we; logic [12:0] raddr; logic [7:0] wem;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [1:0] vld, input logic [1:0] rd,
                             input logic [15:0] a0, input logic [15:0] a1, input logic [63:0] wd,
                             input logic [7:0] wm, input logic [1:0] rr, input logic cg,
                             input logic [1:0] crdy, input logic [1:0] rv, input logic [63:0] rdata,
                             input logic cs, input logic we, input logic [12:0] raddr,
                             input logic [7:0] wem);
    vec_t t;
    t.rst = r; t.vld = vld; t.rd = rd; t.a0 = a0; t.a1 = a1; t.wd = wd; t.wm = wm;
    t.rr = rr; t.cg = cg; t.crdy = crdy; t.rv = rv; t.rdata = rdata;
    t.cs = cs; t.we = we; t.raddr = raddr; t.wem = wem;
    return t;
  endfunction

  localparam logic [63:0] D2  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] M3  = 64'hC0DE_0000_0000_0003;
  localparam logic [63:0] WD  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] WR1 = 64'hC0DE_0000_5566_7788;

  vec_t tbl [20];

  // model state for the random phase
  bit          m_out;
  int          m_owner, m_ptr, g;
  logic [63:0] m_data, n_data;
  bit          hs, can, acc;
  logic [15:0] pa [2];
  logic [63:0] pw [2];
  logic [7:0]  pm [2];

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    mem[2] = D2;

    //           rst vld   rd    a0        a1        wd  wm     rr    cg   crdy  rv    rdata   cs we raddr  wem
    tbl[0]  = v(1, 2'b01, 2'b01, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b00, 2'b00, 0,   0, 0, 13'd0, 8'h00);
    tbl[1]  = v(0, 2'b00, 2'b00, 16'h0000, 16'h0000, 0,  8'h00, 2'b11, 1,  2'b00, 2'b00, 0,   0, 0, 13'd0, 8'h00);
    tbl[2]  = v(0, 2'b01, 2'b01, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b01, 2'b00, 0,   1, 0, 13'd2, 8'h00);
    tbl[3]  = v(0, 2'b00, 2'b00, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b00, 2'b01, D2,  0, 0, 13'd0, 8'h00);
    tbl[4]  = v(0, 2'b11, 2'b11, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b10, 2'b00, 0,   1, 0, 13'd3, 8'h00);
    tbl[5]  = v(0, 2'b11, 2'b11, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b01, 2'b10, M3,  1, 0, 13'd2, 8'h00);
    tbl[6]  = v(0, 2'b11, 2'b11, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b10, 2'b01, D2,  1, 0, 13'd3, 8'h00);
    tbl[7]  = v(0, 2'b11, 2'b11, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b01, 2'b10, M3,  1, 0, 13'd2, 8'h00);
    tbl[8]  = v(0, 2'b11, 2'b11, 16'h0010, 16'h0018, 0,  8'h00, 2'b00, 0,  2'b00, 2'b01, D2,  0, 0, 13'd0, 8'h00);
    tbl[9]  = v(0, 2'b11, 2'b11, 16'h0010, 16'h0018, 0,  8'h00, 2'b00, 0,  2'b00, 2'b01, D2,  0, 0, 13'd0, 8'h00);
    tbl[10] = v(0, 2'b11, 2'b11, 16'h0010, 16'h0018, 0,  8'h00, 2'b00, 0,  2'b00, 2'b01, D2,  0, 0, 13'd0, 8'h00);
    tbl[11] = v(0, 2'b11, 2'b11, 16'h0010, 16'h0018, 0,  8'h00, 2'b01, 0,  2'b10, 2'b01, D2,  1, 0, 13'd3, 8'h00);
    tbl[12] = v(0, 2'b00, 2'b00, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b00, 2'b10, M3,  0, 0, 13'd0, 8'h00);
    tbl[13] = v(0, 2'b10, 2'b00, 16'h0010, 16'h0008, WD, 8'h0F, 2'b11, 0,  2'b10, 2'b00, 0,   1, 1, 13'd1, 8'h0F);
    tbl[14] = v(0, 2'b01, 2'b01, 16'h0008, 16'h0008, WD, 8'h0F, 2'b11, 0,  2'b01, 2'b10, 0,   1, 0, 13'd1, 8'h00);
    tbl[15] = v(0, 2'b00, 2'b00, 16'h0008, 16'h0008, 0,  8'h00, 2'b11, 0,  2'b00, 2'b01, WR1, 0, 0, 13'd0, 8'h00);
    tbl[16] = v(0, 2'b01, 2'b01, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b01, 2'b00, 0,   1, 0, 13'd2, 8'h00);
    tbl[17] = v(1, 2'b00, 2'b00, 16'h0010, 16'h0018, 0,  8'h00, 2'b00, 0,  2'b00, 2'b01, D2,  0, 0, 13'd0, 8'h00);
    tbl[18] = v(0, 2'b11, 2'b11, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b01, 2'b00, 0,   1, 0, 13'd2, 8'h00);
    tbl[19] = v(0, 2'b00, 2'b00, 16'h0010, 16'h0018, 0,  8'h00, 2'b11, 0,  2'b00, 2'b01, D2,  0, 0, 13'd0, 8'h00);

    rst = 1'b1; tcm_cgstop = 1'b0; i_cmd_valid = '0; i_cmd_read = '0; i_cmd_addr = '0;
    i_cmd_wdata = '0; i_cmd_wmask = '0; i_rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < 20; r++) begin
      rst = tbl[r].rst; tcm_cgstop = tbl[r].cg; i_cmd_valid = tbl[r].vld; i_cmd_read = tbl[r].rd;
      i_cmd_addr = {tbl[r].a1, tbl[r].a0}; i_cmd_wdata = {tbl[r].wd, tbl[r].wd};
      i_cmd_wmask = {tbl[r].wm, tbl[r].wm}; i_rsp_ready = tbl[r].rr;
      @(negedge clk);
      chk($sformatf("row%0d cmd_ready", r), 64'(i_cmd_ready), 64'(tbl[r].crdy));
      chk($sformatf("row%0d rsp_valid", r), 64'(i_rsp_valid), 64'(tbl[r].rv));
      chk($sformatf("row%0d rsp_rdata", r), i_rsp_rdata, tbl[r].rdata);
      chk($sformatf("row%0d ram_cs", r), 64'(ram_cs), 64'(tbl[r].cs));
      chk($sformatf("row%0d ram_we", r), 64'(ram_we), 64'(tbl[r].we));
      chk($sformatf("row%0d ram_addr", r), 64'(ram_addr), 64'(tbl[r].raddr));
      chk($sformatf("row%0d ram_wem", r), 64'(ram_wem), 64'(tbl[r].wem));
      chk($sformatf("row%0d ram_clk_en", r), 64'(ram_clk_en), 64'(tbl[r].cs | tbl[r].cg));
      chk($sformatf("row%0d tcm_active", r), 64'(tcm_active), 64'((|tbl[r].vld) | (|tbl[r].rv)));
      @(posedge clk);
      #1;
    end

    // randomized traffic against a transaction-level model
    rst = 1'b1; i_cmd_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0; m_out = 0; m_owner = 0; m_ptr = 0; m_data = '0;
    for (int c = 0; c < 400; c++) begin
      i_cmd_valid = 2'($urandom_range(0, 3));
      i_cmd_read  = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        pa[p] = 16'(($urandom_range(0, 15) << 3) | $urandom_range(0, 7));
        pw[p] = {$urandom, $urandom};
        pm[p] = 8'($urandom_range(0, 255));
        i_rsp_ready[p] = ($urandom_range(0, 9) < 7);
      end
      i_cmd_addr = {pa[1], pa[0]}; i_cmd_wdata = {pw[1], pw[0]}; i_cmd_wmask = {pm[1], pm[0]};
      tcm_cgstop = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      hs  = m_out && i_rsp_ready[m_owner];
      can = !m_out || hs;
      g   = -1;
      for (int i = 0; i < 2; i++)
        if (g < 0 && i_cmd_valid[(m_ptr + i) % 2]) g = (m_ptr + i) % 2;
      acc = can && (g >= 0);
      chk($sformatf("rnd%0d cmd_ready", c), 64'(i_cmd_ready), acc ? 64'(1 << g) : 64'd0);
      chk($sformatf("rnd%0d rsp_valid", c), 64'(i_rsp_valid), m_out ? 64'(1 << m_owner) : 64'd0);
      chk($sformatf("rnd%0d rsp_rdata", c), i_rsp_rdata, m_out ? m_data : 64'd0);
      chk($sformatf("rnd%0d ram_cmd", c), {61'(ram_addr), ram_cs, ram_we, 1'b0},
          acc ? {61'(pa[g] >> 3), 1'b1, !i_cmd_read[g], 1'b0} : 64'd0);
      chk($sformatf("rnd%0d ram_wem", c), 64'(ram_wem), (acc && !i_cmd_read[g]) ? 64'(pm[g]) : 64'd0);
      chk($sformatf("rnd%0d ram_din", c), ram_din, acc ? pw[g] : 64'd0);
      chk($sformatf("rnd%0d ram_clk_en", c), 64'(ram_clk_en), 64'(acc | tcm_cgstop));
      chk($sformatf("rnd%0d tcm_active", c), 64'(tcm_active), 64'((|i_cmd_valid) | m_out));
      n_data = (acc && i_cmd_read[g]) ? mem[pa[g] >> 3] : 64'd0;
      @(posedge clk);
      if (acc) begin
        m_out = 1; m_owner = g; m_data = n_data; m_ptr = (g + 1) % 2;
      end else if (hs) begin
        m_out = 0;
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
